// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator with debounced push-button position control.
// One shared frame counter; each channel's pulse width changes only at frame boundaries.
module servo_pwm_multi #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 20,
  parameter int PERIOD_CNT   = 1_000_000,
  parameter int MIN_CNT      = 50_000,
  parameter int MAX_CNT      = 100_000,
  parameter int CENTER_CNT   = 75_000,
  parameter int STEP_CNT     = 5_000,
  parameter int DEBOUNCE_CNT = 500_000,
  parameter bit BTN_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       btn_inc,
  input  logic [NUM_CH-1:0]       btn_dec,
  output logic [NUM_CH-1:0]       servo,
  output logic                    frame_start,
  output logic [NUM_CH*CNT_W-1:0] pos
);

  localparam int NB   = 2 * NUM_CH;
  localparam int DB_W = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CNT - 1);
  localparam logic [CNT_W-1:0] CENTER_V    = CNT_W'(CENTER_CNT);
  localparam logic [CNT_W-1:0] MIN_V       = CNT_W'(MIN_CNT);
  localparam logic [CNT_W-1:0] MAX_V       = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] STEP_V      = CNT_W'(STEP_CNT);
  localparam logic [CNT_W:0]   MIN_X       = (CNT_W+1)'(MIN_CNT);
  localparam logic [CNT_W:0]   MAX_X       = (CNT_W+1)'(MAX_CNT);
  localparam logic [CNT_W:0]   STEP_X      = (CNT_W+1)'(STEP_CNT);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CNT - 1);

  if (NUM_CH < 1 || STEP_CNT < 1 || DEBOUNCE_CNT < 1 ||
      MIN_CNT > CENTER_CNT || CENTER_CNT > MAX_CNT || MAX_CNT >= PERIOD_CNT ||
      longint'(PERIOD_CNT) > (longint'(1) << CNT_W)) begin : g_illegal_params
    $error("servo_pwm_multi: illegal parameter combination");
  end

  // Saturating step up/down, evaluated one bit wider so neither bound can wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W:0] s;
    s = {1'b0, v} + STEP_X;
    if (s > MAX_X) return MAX_V;
    return s[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    if ({1'b0, v} < MIN_X + STEP_X) return MIN_V;
    return v - STEP_V;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tgt [NUM_CH];
  logic [CNT_W-1:0] act [NUM_CH];
  logic [NB-1:0]    raw, sync_p0, sync_p1, db, press;
  logic [DB_W-1:0]  dcnt [NB];

  // Frame counter, free-running regardless of enable
  always_ff @(posedge clk) begin
    if (rst || cnt == PERIOD_LAST) cnt <= '0;
    else                           cnt <= cnt + CNT_W'(1);
  end

  assign frame_start = (cnt == '0) && !rst;

  // Button stage p0/p1: two-flop synchroniser, normalised so 1 means pressed
  assign raw = {btn_dec, btn_inc} ^ {NB{BTN_ACT_LOW}};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce stage: accept a new level only after DEBOUNCE_CNT consecutive disagreeing cycles
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (rst) begin
        db[b]   <= 1'b0;
        dcnt[b] <= '0;
      end else if (sync_p1[b] == db[b]) begin
        dcnt[b] <= '0;
      end else if (dcnt[b] == DB_LAST) begin
        db[b]   <= sync_p1[b];
        dcnt[b] <= '0;
      end else begin
        dcnt[b] <= dcnt[b] + DB_W'(1);
      end
    end
  end

  always_comb begin
    press = '0;
    for (int b = 0; b < NB; b++)
      press[b] = sync_p1[b] && !db[b] && (dcnt[b] == DB_LAST);
  end

  // Target/commit stage: bits [NUM_CH-1:0] of press are inc, upper half are dec
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        tgt[i] <= CENTER_V;
        act[i] <= CENTER_V;
      end else begin
        if (press[i] && !press[NUM_CH+i])      tgt[i] <= sat_inc(tgt[i]);
        else if (!press[i] && press[NUM_CH+i]) tgt[i] <= sat_dec(tgt[i]);
        if (cnt == PERIOD_LAST)                act[i] <= tgt[i];
      end
    end
  end

  // Output stage: registered compare, so the rising edge trails cnt==0 by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      servo <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        servo[i] <= enable && (cnt < act[i]);
    end
  end

  always_comb begin
    pos = '0;
    for (int i = 0; i < NUM_CH; i++)
      pos[i*CNT_W +: CNT_W] = act[i];
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi: table of button sequences plus hand-written corner cases.
module tb_servo_pwm_multi;

  localparam int CNT_W  = 10;
  localparam int PERIOD = 1000;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [1:0] btn_inc, btn_dec;
  logic [1:0] servo;
  logic       frame_start;
  logic [2*CNT_W-1:0] pos;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    int ch;
    bit inc;
    bit dec;
    int n;
    int exp0;
    int exp1;
  } vec_t;

  vec_t tbl [10];

  servo_pwm_multi #(
    .NUM_CH(2), .CNT_W(CNT_W), .PERIOD_CNT(PERIOD), .MIN_CNT(50), .MAX_CNT(100),
    .CENTER_CNT(75), .STEP_CNT(5), .DEBOUNCE_CNT(8), .BTN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .servo(servo), .frame_start(frame_start), .pos(pos)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  // Active-low buttons: 0 = pressed, 1 = released
  task automatic press(input int ch, input bit inc, input bit dec, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (inc) btn_inc[ch] = 1'b0;
      if (dec) btn_dec[ch] = 1'b0;
      repeat (20) @(negedge clk);
      btn_inc = 2'b11;
      btn_dec = 2'b11;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 3 * PERIOD);
    if (!frame_start) chk("frame_start_timeout", 32'd0, 32'd1);
  endtask

  // Call at a negedge where cnt==0; returns at the next such negedge.
  task automatic count_frame(output int w0, output int w1, output int fs_hits);
    w0 = 0; w1 = 0; fs_hits = 0;
    for (int k = 0; k < PERIOD; k++) begin
      @(negedge clk);
      if (servo[0] === 1'b1) w0++;
      if (servo[1] === 1'b1) w1++;
      if (frame_start === 1'b1) fs_hits++;
    end
  endtask

  int w0, w1, fsh;

  initial begin
    tbl[0] = '{0, 1'b1, 1'b0, 1, 85, 75};
    tbl[1] = '{0, 1'b1, 1'b0, 6, 100, 75};
    tbl[2] = '{0, 1'b1, 1'b0, 1, 100, 75};
    tbl[3] = '{1, 1'b0, 1'b1, 2, 100, 65};
    tbl[4] = '{0, 1'b0, 1'b1, 6, 70, 65};
    tbl[5] = '{0, 1'b0, 1'b1, 6, 50, 65};
    tbl[6] = '{0, 1'b0, 1'b1, 1, 50, 65};
    tbl[7] = '{1, 1'b1, 1'b0, 3, 50, 80};
    tbl[8] = '{0, 1'b1, 1'b1, 1, 50, 80};
    tbl[9] = '{1, 1'b1, 1'b1, 2, 50, 80};

    rst = 1'b1; enable = 1'b0; btn_inc = 2'b11; btn_dec = 2'b11;
    repeat (5) @(negedge clk);
    chk("reset_servo", 32'(servo), 32'd0);
    chk("reset_frame_start", 32'(frame_start), 32'd0);
    chk("reset_pos", 32'(pos), {12'd0, 10'd75, 10'd75});

    enable = 1'b1;
    rst = 1'b0;
    #1;
    chk("first_frame_start", 32'(frame_start), 32'd1);
    count_frame(w0, w1, fsh);
    chk("center_w0", w0, 75);
    chk("center_w1", w1, 75);
    chk("period_fs_hits", fsh, 1);
    chk("period_fs_at_1000", 32'(frame_start), 32'd1);

    // Press ch0 inc partway through a frame: this frame keeps 75, the next shows 80
    fork
      count_frame(w0, w1, fsh);
      begin
        repeat (10) @(negedge clk);
        press(0, 1'b1, 1'b0, 1);
        chk("midframe_pos0_held", 32'(pos[CNT_W-1:0]), 32'd75);
      end
    join
    chk("midframe_w0_old", w0, 75);
    chk("midframe_pos0_new", 32'(pos[CNT_W-1:0]), 32'd80);
    count_frame(w0, w1, fsh);
    chk("midframe_w0_new", w0, 80);
    chk("midframe_w1", w1, 75);

    for (int t = 0; t < 10; t++) begin
      press(tbl[t].ch, tbl[t].inc, tbl[t].dec, tbl[t].n);
      wait_fs();
      chk($sformatf("tbl%0d_pos0", t), 32'(pos[CNT_W-1:0]), 32'(tbl[t].exp0));
      chk($sformatf("tbl%0d_pos1", t), 32'(pos[2*CNT_W-1:CNT_W]), 32'(tbl[t].exp1));
    end

    // Short glitch on dec must be rejected by the debouncer
    @(negedge clk);
    btn_dec[1] = 1'b0;
    repeat (5) @(negedge clk);
    btn_dec[1] = 1'b1;
    repeat (30) @(negedge clk);
    wait_fs();
    chk("glitch_pos1", 32'(pos[2*CNT_W-1:CNT_W]), 32'd80);
    count_frame(w0, w1, fsh);
    chk("final_w0", w0, 50);
    chk("final_w1", w1, 80);

    // Enable drop mid-pulse, target change while disabled, reassert mid-frame
    repeat (20) @(negedge clk);
    chk("en_servo_high", 32'(servo), 32'd3);
    enable = 1'b0;
    @(negedge clk);
    chk("en_off_servo_low", 32'(servo), 32'd0);
    press(1, 1'b1, 1'b0, 1);
    wait_fs();
    chk("en_off_pos1", 32'(pos[2*CNT_W-1:CNT_W]), 32'd85);
    count_frame(w0, w1, fsh);
    chk("en_off_w0", w0, 0);
    chk("en_off_w1", w1, 0);
    repeat (20) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("en_resume_servo", 32'(servo), 32'd3);

    // Reset asserted mid-pulse
    wait_fs();
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_servo", 32'(servo), 32'd0);
    chk("midrst_pos", 32'(pos), {12'd0, 10'd75, 10'd75});
    chk("midrst_frame_start", 32'(frame_start), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_cnt_zero", 32'(frame_start), 32'd1);
    count_frame(w0, w1, fsh);
    chk("midrst_w0", w0, 75);
    chk("midrst_w1", w1, 75);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
